// File: rtl/riscv_pkg.sv
// Shared fetch definitions: FSM state encoding, EBREAK opcode, PC step.
// Optional feature macro: FETCH_HALT_EBREAK_EN adds the HALT state.
package riscv_pkg;

  // EBREAK instruction encoding (SYSTEM opcode, imm=1)
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  // Byte increment between sequential 32-bit instructions
  localparam int unsigned PC_INC = 4;

`ifdef FETCH_HALT_EBREAK_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a combinational ROM from the fetch
// pointer, registers one instruction toward the consumer with valid/ready
// backpressure, and accepts redirects that flush the held instruction.
// Optional feature macro: FETCH_HALT_EBREAK_EN -- stop fetching once an
// EBREAK has been loaded; resume only on redirect or reset.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic              halt_o
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc_q;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;

  logic              w_accept;
  logic              w_advance;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Output register may be refilled when empty or being consumed this cycle
  assign w_accept      = r_valid & instr_ready_i;
  assign w_advance     = ~r_valid | instr_ready_i;
  // Natural wrap at 2^ADDR_W, no overflow indication
  assign w_pc_inc      = r_pc_q + ADDR_W'(PC_INC);
  // Targets are word aligned; low byte-offset bits are discarded
  assign w_redirect_pc = {redirect_addr_i[ADDR_W-1:2], 2'b00};

`ifdef FETCH_HALT_EBREAK_EN
  logic r_halt;
  logic w_is_ebreak;

  assign w_is_ebreak = (rom_data_i == DATA_W'(EBREAK_INSN));
  assign halt_o      = r_halt;

  // Fetch FSM: redirect wins, then halt drain, then run/stall handshake
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state    <= ST_RUN;
      r_pc_q     <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_halt     <= 1'b0;
    end else if (redirect_valid_i) begin
      r_state <= ST_RUN;
      r_pc_q  <= w_redirect_pc;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        ST_HALT: begin
          // EBREAK stays presented until taken, then output goes empty
          if (w_accept) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          if (w_advance) begin
            r_instr    <= rom_data_i;
            r_instr_pc <= r_pc_q;
            r_valid    <= 1'b1;
            r_pc_q     <= w_pc_inc;
            if (w_is_ebreak) begin
              r_state <= ST_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_state <= ST_STALL;
          end
        end
      endcase
    end
  end
`else
  assign halt_o = 1'b0;

  // Fetch FSM: redirect wins, otherwise run/stall handshake
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state    <= ST_RUN;
      r_pc_q     <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (redirect_valid_i) begin
      r_state <= ST_RUN;
      r_pc_q  <= w_redirect_pc;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        default: begin
          if (w_advance) begin
            r_instr    <= rom_data_i;
            r_instr_pc <= r_pc_q;
            r_valid    <= 1'b1;
            r_pc_q     <= w_pc_inc;
            r_state    <= ST_RUN;
          end else begin
            r_state <= ST_STALL;
          end
        end
      endcase
    end
  end
`endif

  assign rom_addr_o    = r_pc_q;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;

endmodule
